// File: rtl/cam_pkg.sv
// Shared constants, state encoding and RGB565 field layout for the camera capture path.
package cam_pkg;

  localparam int CAM_H_ACTIVE = 640;
  localparam int CAM_V_ACTIVE = 480;
  localparam int CAM_DEPTH    = 320 * 240;
  localparam int CAM_ADDR_W   = 19;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_VBLANK,
    ST_ACTIVE
  } cap_state_t;

  // RGB565 arrives as hi = RRRRRGGG, lo = GGGBBBBB; these are the MSB positions.
  localparam int R565_MSB    = 7;
  localparam int G565_HI_MSB = 2;
  localparam int G565_LO_MSB = 7;
  localparam int B565_MSB    = 4;

  function automatic logic [11:0] rgb565_to_444(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[R565_MSB -: 4], hi[G565_HI_MSB -: 3], lo[G565_LO_MSB], lo[B565_MSB -: 4]};
  endfunction

endpackage

// File: rtl/cam_capture_if.sv
// Frame-buffer write port: one strobe, RGB444 word and linear address per kept pixel.
interface cam_capture_if #(
  parameter int ADDR_W = 19
);
  logic              pix_wr;
  logic [11:0]       pix_data;
  logic [ADDR_W-1:0] pix_addr;

  modport master (output pix_wr, output pix_data, output pix_addr);
  modport slave  (input  pix_wr, input  pix_data, input  pix_addr);
endinterface

// File: rtl/cam_rgb444_pack.sv
// Registered output stage: packs the RGB565 pair to RGB444 and holds data/address between strobes.
module cam_rgb444_pack
  import cam_pkg::*;
#(
  parameter int ADDR_W = CAM_ADDR_W
) (
  input  logic              pclk,
  input  logic              rstn_pclk,
  input  logic [7:0]        hi,
  input  logic [7:0]        lo,
  input  logic              keep,
  input  logic [ADDR_W-1:0] addr_next,
  cam_capture_if.master     wr
);

  always_ff @(posedge pclk or negedge rstn_pclk) begin
    if (!rstn_pclk) begin
      wr.pix_wr   <= 1'b0;
      wr.pix_data <= '0;
      wr.pix_addr <= '0;
    end else begin
      wr.pix_wr <= keep;
      if (keep) begin
        wr.pix_data <= rgb565_to_444(hi, lo);
        wr.pix_addr <= addr_next;
      end
    end
  end

endmodule

// File: rtl/cam_capture.sv
// OV7670 capture: frames the byte stream, decimates 2:1 in both axes and writes RGB444 to the frame BRAM.
module cam_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = CAM_H_ACTIVE,
  parameter int V_ACTIVE = CAM_V_ACTIVE,
  parameter int DEPTH    = CAM_DEPTH,
  parameter int ADDR_W   = CAM_ADDR_W
) (
  input  logic       pclk,
  input  logic       rstn_pclk,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] pix_byte,
  input  logic       cap_en,
  output logic       frame_done,
  cam_capture_if.master wr
);

  localparam int COL_W = $clog2(H_ACTIVE + 1);
  localparam int ROW_W = $clog2(V_ACTIVE + 1);

  logic              vsync_q, href_q, vsync_d, href_d;
  logic [7:0]        byte_q;
  cap_state_t        state_reg;
  logic              frame_en_reg;
  logic              phase_reg;
  logic [7:0]        hi_reg;
  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [ADDR_W-1:0] addr_cnt_reg;
  logic              frame_done_reg;

  logic vs_rise, vs_fall, href_fall, pix_done, in_range, keep;

  always_ff @(posedge pclk or negedge rstn_pclk) begin
    if (!rstn_pclk) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      byte_q  <= '0;
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
      byte_q  <= pix_byte;
      vsync_d <= vsync_q;
      href_d  <= href_q;
    end
  end

  assign vs_rise   = vsync_q & ~vsync_d;
  assign vs_fall   = ~vsync_q & vsync_d;
  assign href_fall = ~href_q & href_d;

  // A pixel completing in the same cycle vsync rises belongs to an aborted line and is dropped,
  // so the last write always lands one cycle before frame_done.
  assign pix_done = (state_reg == ST_ACTIVE) & href_q & phase_reg & ~vs_rise;
  assign in_range = (col_reg < COL_W'(H_ACTIVE)) & (row_reg < ROW_W'(V_ACTIVE));
  assign keep     = pix_done & ~col_reg[0] & ~row_reg[0] & in_range & frame_en_reg
                  & (addr_cnt_reg < ADDR_W'(DEPTH));

  always_ff @(posedge pclk or negedge rstn_pclk) begin
    if (!rstn_pclk) begin
      state_reg      <= ST_WAIT;
      frame_en_reg   <= 1'b0;
      phase_reg      <= 1'b0;
      hi_reg         <= '0;
      col_reg        <= '0;
      row_reg        <= '0;
      addr_cnt_reg   <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        ST_WAIT: begin
          if (vsync_q) state_reg <= ST_VBLANK;
        end
        ST_VBLANK: begin
          if (vs_fall) begin
            state_reg    <= ST_ACTIVE;
            frame_en_reg <= cap_en;
            addr_cnt_reg <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            phase_reg    <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (vs_rise) begin
            state_reg      <= ST_VBLANK;
            frame_done_reg <= frame_en_reg;
            phase_reg      <= 1'b0;
          end else if (href_q) begin
            phase_reg <= ~phase_reg;
            if (!phase_reg) begin
              hi_reg <= byte_q;
            end else begin
              // Counters stop at the limit so overlong lines/frames never wrap back into range.
              if (col_reg < COL_W'(H_ACTIVE)) col_reg <= col_reg + 1'b1;
              if (keep) addr_cnt_reg <= addr_cnt_reg + 1'b1;
            end
          end else if (href_fall) begin
            phase_reg <= 1'b0;
            col_reg   <= '0;
            if (row_reg < ROW_W'(V_ACTIVE)) row_reg <= row_reg + 1'b1;
          end
        end
        default: state_reg <= ST_WAIT;
      endcase
    end
  end

  assign frame_done = frame_done_reg;

  cam_rgb444_pack #(
    .ADDR_W(ADDR_W)
  ) u_pack (
    .pclk      (pclk),
    .rstn_pclk (rstn_pclk),
    .hi        (hi_reg),
    .lo        (byte_q),
    .keep      (keep),
    .addr_next (addr_cnt_reg),
    .wr        (wr)
  );

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a scaled 32x12 source (16x6 destination).
module tb_cam_capture;

  localparam int H  = 32;
  localparam int V  = 12;
  localparam int D  = 96;
  localparam int AW = 19;

  logic       pclk = 1'b0;
  logic       rstn_pclk = 1'b0;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic       cap_en = 1'b0;
  logic [7:0] pix_byte = 8'h00;
  logic       frame_done;

  cam_capture_if #(.ADDR_W(AW)) wr_if ();

  cam_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .DEPTH(D), .ADDR_W(AW)
  ) dut (
    .pclk       (pclk),
    .rstn_pclk  (rstn_pclk),
    .vsync      (vsync),
    .href       (href),
    .pix_byte   (pix_byte),
    .cap_en     (cap_en),
    .frame_done (frame_done),
    .wr         (wr_if)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc++;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fails++;
      $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  // Write-port monitor; statistics are cleared on request from the stimulus process.
  int wr_cnt, fd_cnt, coinc, nonseq, not_f0f, dup, wr_after_fd, hold_viol;
  int min_gap = 1000, max_addr, first_addr, last_addr, last_wr_cyc, first_wr_cyc;
  logic [11:0]   shadow [0:127];
  bit            shadow_set [0:127];
  logic [11:0]   prev_data;
  logic [AW-1:0] prev_addr;
  int clr_req = 0, clr_seen = 0;

  always @(negedge pclk) begin
    int a;
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      wr_cnt = 0; fd_cnt = 0; coinc = 0; nonseq = 0; not_f0f = 0; dup = 0;
      wr_after_fd = 0; hold_viol = 0; min_gap = 1000; max_addr = 0;
      first_addr = -1; last_addr = -1; last_wr_cyc = 0; first_wr_cyc = 0;
      for (int i = 0; i < 128; i++) shadow_set[i] = 1'b0;
    end
    if (rstn_pclk) begin
      if (wr_if.pix_wr) begin
        a = int'(wr_if.pix_addr);
        if (wr_cnt == 0) begin
          first_wr_cyc = cyc;
          first_addr   = a;
        end else begin
          if (a != last_addr + 1) nonseq++;
          if (cyc - last_wr_cyc < min_gap) min_gap = cyc - last_wr_cyc;
        end
        wr_cnt++;
        last_wr_cyc = cyc;
        last_addr   = a;
        if (a > max_addr) max_addr = a;
        if (wr_if.pix_data !== 12'hF0F) not_f0f++;
        if (fd_cnt > 0) wr_after_fd++;
        if (a < 128) begin
          if (shadow_set[a]) dup++;
          shadow_set[a] = 1'b1;
          shadow[a]     = wr_if.pix_data;
        end
      end else if (wr_if.pix_data !== prev_data || wr_if.pix_addr !== prev_addr) begin
        hold_viol++;
      end
      if (frame_done) begin
        fd_cnt++;
        if (wr_if.pix_wr) coinc++;
      end
    end
    prev_data = wr_if.pix_data;
    prev_addr = wr_if.pix_addr;
  end

  task automatic clear_stats();
    clr_req++;
    @(negedge pclk);
    #1;
  endtask

  task automatic step(input logic v, input logic h, input logic [7:0] b);
    @(posedge pclk);
    #1;
    vsync    = v;
    href     = h;
    pix_byte = b;
  endtask

  // mode 0: every pixel F8/1F (RGB444 0xF0F); mode 1: R = c[4:1], G = 0, B = r[4:1].
  int mode = 0;
  int lat_drive_cyc = 0;

  task automatic send_line(input int nbytes, input int r, input int vs_at);
    logic [31:0] cv, rv;
    logic [7:0]  hb, lb;
    logic        v;
    for (int i = 0; i < nbytes; i++) begin
      cv = 32'(i / 2);
      rv = 32'(r);
      v  = (vs_at >= 0) && (i >= vs_at);
      if (mode == 0) begin
        hb = 8'hF8;
        lb = 8'h1F;
      end else begin
        hb = {cv[4:1], 4'h0};
        lb = {3'b000, rv[4:1], 1'b0};
      end
      step(v, 1'b1, (i % 2 == 0) ? hb : lb);
      if (i == 1 && r == 0) lat_drive_cyc = cyc;
    end
    for (int i = 0; i < 4; i++) step(vs_at >= 0, 1'b0, 8'h00);
  endtask

  task automatic start_frame();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic end_frame();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic send_lines(input int r0, input int r1, input int nbytes);
    for (int r = r0; r < r1; r++) send_line(nbytes, r, -1);
  endtask

  initial begin
    int bad;
    logic [11:0] e;

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_pix_wr",     int'(wr_if.pix_wr),   0);
    check("rst_pix_data",   int'(wr_if.pix_data), 0);
    check("rst_pix_addr",   int'(wr_if.pix_addr), 0);
    check("rst_frame_done", int'(frame_done),     0);
    @(posedge pclk);
    #1;
    rstn_pclk = 1'b1;
    cap_en    = 1'b1;

    // Mid-frame entry: lines without any vsync edge must not be captured.
    clear_stats();
    send_lines(0, 4, 64);
    check("entry_wr_cnt", wr_cnt, 0);
    check("entry_fd_cnt", fd_cnt, 0);

    // Full frame, solid colour.
    clear_stats();
    start_frame();
    send_lines(0, V, 64);
    end_frame();
    check("full_wr_cnt",     wr_cnt, 96);
    check("full_bad_data",   not_f0f, 0);
    check("full_first_addr", first_addr, 0);
    check("full_last_addr",  last_addr, 95);
    check("full_nonseq",     nonseq, 0);
    check("full_fd_cnt",     fd_cnt, 1);
    check("full_fd_with_wr", coinc, 0);
    check("full_latency",    first_wr_cyc - lat_drive_cyc, 2);
    check("full_min_gap",    min_gap, 4);
    check("full_hold",       hold_viol, 0);
    check("full_held_addr",  int'(wr_if.pix_addr), 95);
    check("full_held_data",  int'(wr_if.pix_data), 12'hF0F);

    // Decimation and ordering with position-coded pixels.
    mode = 1;
    clear_stats();
    start_frame();
    send_lines(0, V, 64);
    end_frame();
    bad = 0;
    for (int a = 0; a < 96; a++) begin
      e = {4'(a % 16), 4'h0, 4'(a / 16)};
      if (!shadow_set[a] || shadow[a] !== e) bad++;
    end
    check("dec_wr_cnt", wr_cnt, 96);
    check("dec_bad",    bad, 0);
    check("dec_dup",    dup, 0);
    check("dec_px17",   int'(shadow[17]), 12'h101);
    check("dec_px40",   int'(shadow[40]), 12'h802);
    check("dec_px95",   int'(shadow[95]), 12'hF05);

    // Odd byte counts and a short line.
    clear_stats();
    start_frame();
    send_line(65, 0, -1);
    send_line(65, 1, -1);
    send_line(40, 2, -1);
    send_line(64, 3, -1);
    send_line(64, 4, -1);
    end_frame();
    check("odd_wr_cnt", wr_cnt, 42);
    check("odd_nonseq", nonseq, 0);
    check("odd_last",   last_addr, 41);
    check("odd_px15",   int'(shadow[15]), 12'hF00);
    check("odd_px16",   int'(shadow[16]), 12'h001);
    check("odd_px25",   int'(shadow[25]), 12'h901);
    check("odd_px26",   int'(shadow[26]), 12'h002);
    check("odd_px41",   int'(shadow[41]), 12'hF02);
    check("odd_fd_cnt", fd_cnt, 1);

    // Overlong lines and frame.
    mode = 0;
    clear_stats();
    start_frame();
    send_lines(0, 16, 80);
    end_frame();
    check("long_wr_cnt",   wr_cnt, 96);
    check("long_max_addr", max_addr, 95);
    check("long_nonseq",   nonseq, 0);
    check("long_fd_cnt",   fd_cnt, 1);

    // cap_en low at frame start, raised mid-frame.
    cap_en = 1'b0;
    clear_stats();
    start_frame();
    send_lines(0, 2, 64);
    cap_en = 1'b1;
    send_lines(2, V, 64);
    end_frame();
    check("capen_wr_cnt", wr_cnt, 0);
    check("capen_fd_cnt", fd_cnt, 0);

    // vsync rising mid-line.
    clear_stats();
    start_frame();
    send_lines(0, 2, 64);
    send_line(20, 2, 11);
    end_frame();
    check("mvs_fd_cnt",     fd_cnt, 1);
    check("mvs_wr_cnt",     wr_cnt, 19);
    check("mvs_wr_after",   wr_after_fd, 0);
    check("mvs_fd_with_wr", coinc, 0);

    // Asynchronous reset in the middle of a frame.
    clear_stats();
    start_frame();
    send_lines(0, 4, 64);
    check("rsta_pre_addr", int'(wr_if.pix_addr), 31);
    @(posedge pclk);
    #2;
    rstn_pclk = 1'b0;
    #1;
    check("rsta_pix_wr",     int'(wr_if.pix_wr),   0);
    check("rsta_pix_data",   int'(wr_if.pix_data), 0);
    check("rsta_pix_addr",   int'(wr_if.pix_addr), 0);
    check("rsta_frame_done", int'(frame_done),     0);
    @(posedge pclk);
    #1;
    rstn_pclk = 1'b1;
    clear_stats();
    send_lines(4, V, 64);
    end_frame();
    check("rsta_rest_wr", wr_cnt, 0);
    check("rsta_rest_fd", fd_cnt, 0);
    clear_stats();
    start_frame();
    send_lines(0, V, 64);
    end_frame();
    check("rsta_resume_wr", wr_cnt, 96);
    check("rsta_resume_fd", fd_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cam_capture.md
# cam_capture

Pixel capture stage between the OV7670 parallel bus and the frame BRAM write port, running entirely in the camera `pclk` domain. It frames the byte stream with `vsync`/`href` and packs RGB565 byte pairs into RGB444 words. It decimates the 640x480 source 2:1 in both axes and emits one write strobe, data word and linear address per kept pixel, which feeds the 320x240 `bram_mem` write side. It also reports frame completion to `cam_ctrl`.

## Interface
- `H_ACTIVE`, 640, source pixels per line.
- `V_ACTIVE`, 480, source lines per frame.
- `DEPTH`, 320*240, destination pixels; writes never exceed `DEPTH-1`.
- `ADDR_W`, 19, width of `pix_addr`.
- `pclk` in 1: camera pixel clock; the only clock.
- `rstn_pclk` in 1: reset, asynchronous and active-low; already synchronized to `pclk` upstream.
- `vsync` in 1: camera vertical sync; high = vertical blank.
- `href` in 1: camera line-valid; high = bytes valid.
- `pix_byte` in 8: camera data byte.
- `cap_en` in 1: capture enable; sampled only at frame start.
- `pix_wr` out 1: one-cycle BRAM write strobe.
- `pix_data` out 12: RGB444 pixel, `{R[3:0],G[3:0],B[3:0]}`.
- `pix_addr` out `ADDR_W`: linear BRAM address, row-major.
- `frame_done` out 1: one-cycle pulse at the end of each captured frame.

## Operation
- Input stage: `vsync`, `href` and `pix_byte` are registered on every `pclk` rising edge to form `vsync_q`, `href_q` and `byte_q`. All logic below uses only the registered copies. The previous values are kept in `vsync_d` and `href_d` for edge detection.
- The state machine has three states.
  - `ST_WAIT` is entered on reset. It moves to `ST_VBLANK` when `vsync_q` is 1, so capture never starts mid-frame.
  - `ST_VBLANK` moves to `ST_ACTIVE` on the falling edge of `vsync_q`. On that transition, `cap_en` is latched into `frame_en`, and the address, row, column and byte-phase counters are cleared.
  - `ST_ACTIVE` moves to `ST_VBLANK` on the rising edge of `vsync_q`. `frame_done` pulses on that transition only when `frame_en` = 1.
- Byte phase: in `ST_ACTIVE`, while `href_q` = 1, the phase toggles every cycle.
  - Phase 0 stores `byte_q` as `hi`.
  - Phase 1 completes a pixel from `hi` and `byte_q`, then increments `col`.
- Packing (RGB565 to RGB444):
  - R = `hi[7:4]`
  - G = `{hi[2:0], byte_q[7]}`
  - B = `byte_q[4:1]`
- Line end: on the falling edge of `href_q`, the phase is forced to 0 and any half pixel is discarded. `col` is cleared and `row` is incremented.
- Keep rule: a completed pixel is written only when all of these hold:
  - `col[0]` = 0 and `row[0]` = 0
  - `col < H_ACTIVE` and `row < V_ACTIVE`
  - `frame_en` = 1
  - `pix_addr_next < DEPTH`
- Address: `pix_addr` holds the address of the last write. Each kept pixel increments the address counter by 1. The counter saturates; excess pixels are dropped silently.
- Overlong lines and frames: pixels beyond `H_ACTIVE` in a line, or lines beyond `V_ACTIVE` in a frame, are dropped with no wrap.
- `vsync_q` rising mid-line: the line is aborted and the partial pixel is discarded. `frame_done` still pulses (when `frame_en` = 1).
- `cap_en` falling mid-frame: no effect until the next frame start.

## Timing
- Reset values:
  - `pix_wr` = 0, `pix_data` = 0, `pix_addr` = 0, `frame_done` = 0
  - State = `ST_WAIT`
  - All counters and phase = 0
- Latency: if the second byte of a pixel is on the pins at edge N, then `pix_wr`, `pix_data` and `pix_addr` are valid after edge N+2. This is one input register plus one output register.
- `pix_wr` is high for exactly one cycle, at most once every 2 `pclk` cycles. At the nominal 2:1 decimation it occurs once every 4 cycles during a kept line.
- `pix_data` and `pix_addr` are held stable between strobes.
- `frame_done` is asserted after the edge following the `vsync_q` rise. It never coincides with a `pix_wr` for the same frame, because writes drain one cycle earlier.
- Asserting `rstn_pclk` mid-frame clears all outputs immediately. Capture resumes only after a full `vsync` high-then-low sequence.

## Structure
- The shared package `cam_pkg` holds:
  - the state encoding (`ST_WAIT`, `ST_VBLANK`, `ST_ACTIVE`)
  - the RGB565 field positions
  - the default `H_ACTIVE`, `V_ACTIVE` and `DEPTH` constants, which are also used by `vga_ctrl` and `bram_mem` instantiations
- Sub-module `cam_rgb444_pack` is the registered pack-and-output stage. It takes `hi`, `lo`, `keep` and `addr_next`, and drives `pix_wr`, `pix_data` and `pix_addr`.

## Test plan
- **Reset then mid-frame entry.** Release reset with `vsync` = 0 and `href` toggling → no `pix_wr` until a `vsync` 1→0 transition.
- **Full frame, 640x480.** Drive bytes 0xF8 then 0x1F for every pixel, with `cap_en` = 1 → expect:
  - exactly 76800 `pix_wr` pulses
  - `pix_data` = 0xF0F for every write
  - last `pix_addr` = 76799
  - one `frame_done` pulse
- **Decimation and order.** Give pixel (c,r) bytes encoding R = c[4:1] and B = r[4:1] → the write at address r/2*320 + c/2 carries matching R and B. No odd row or column is ever written.
- **Odd byte count and short line.** A line with 641 bytes and a line with 200 pixels → the half pixel is dropped, the short line yields 100 writes, and addresses stay contiguous.
- **Overlong frame.** 500 lines → no write with `pix_addr` > 76799 and no address wrap.
- **`cap_en` and mid-line vsync.**
  - `cap_en` = 0 at frame start, raised mid-frame → zero writes and no `frame_done` for that frame.
  - `vsync` rising mid-line → `frame_done` pulses and no write follows.
